// File: rtl/soin_bpredictor_resolve_pkg.sv
// Shared field offsets and counter constants for branch-resolve and predictor training.
// Meta layouts: fetch meta {ras, ctr byte, lu index}, update meta {ras, be, new byte, index}.
package soin_bpredictor_resolve_pkg;

    localparam int RAS_HI     = 23;
    localparam int RAS_LO     = 20;
    localparam int BE_HI      = 19;
    localparam int BE_LO      = 16;
    localparam int BYTE_HI    = 15;
    localparam int BYTE_LO    = 8;
    localparam int IDX_HI     = 7;
    localparam int IDX_LO     = 0;
    localparam int LU_IDX_HI  = 11;
    localparam int LU_IDX_LO  = 0;
    localparam int IN_BYTE_HI = 19;
    localparam int IN_BYTE_LO = 12;

    localparam int CTR_W = 2;
    localparam logic [CTR_W-1:0] CTR_SAT_MAX = 2'd3;
    localparam logic [CTR_W-1:0] CTR_SAT_MIN = 2'd0;

endpackage

// File: rtl/soin_bpredictor_ctr_update.sv
// Trains one 2-bit saturating counter inside a packed byte of four counters.
// Purely combinational; the other three slots pass through untouched.
module soin_bpredictor_ctr_update
    import soin_bpredictor_resolve_pkg::*;
#(
    parameter logic [CTR_W-1:0] CTR_MAX = CTR_SAT_MAX
) (
    input  logic [7:0] i_byte,
    input  logic [1:0] i_slot,
    input  logic       i_dir,
    output logic [7:0] o_byte
);

    logic [CTR_W-1:0] w_ctr;
    logic [CTR_W-1:0] w_next;

    always_comb begin
        w_ctr  = i_byte[{i_slot, 1'b0} +: CTR_W];
        w_next = w_ctr;
        if (i_dir) begin
            if (w_ctr != CTR_MAX) w_next = w_ctr + 2'd1;
        end else begin
            if (w_ctr != CTR_SAT_MIN) w_next = w_ctr - 2'd1;
        end
        o_byte = i_byte;
        o_byte[{i_slot, 1'b0} +: CTR_W] = w_next;
    end

endmodule

// File: rtl/soin_bpredictor_resolve.sv
// Execute-side branch resolve: one-cycle registered update bundle, redirect and RAS recovery.
// resolve_stall freezes every register; SOIN_BPU_FWD_EN adds a last-write byte forward.
module soin_bpredictor_resolve
    import soin_bpredictor_resolve_pkg::*;
#(
    parameter int META_W  = 24,
    parameter int CTR_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              resolve_stall,
    input  logic              ex_valid,
    input  logic [31:0]       ex_PC,
    input  logic [META_W-1:0] ex_meta,
    input  logic              ex_p_dir,
    input  logic [31:0]       ex_p_target,
    input  logic              ex_is_cond,
    input  logic              ex_is_call,
    input  logic              ex_is_ret,
    input  logic              ex_epoch,
    input  logic              ex_a_dir,
    input  logic [31:0]       ex_a_target,
    output logic              execute_bpredictor_update,
    output logic [31:0]       execute_bpredictor_PC,
    output logic [31:0]       execute_bpredictor_target,
    output logic              execute_bpredictor_dir,
    output logic              execute_bpredictor_miss,
    output logic [META_W-1:0] execute_bpredictor_meta,
    output logic              execute_bpredictor_recover_ras,
    output logic              resolve_redirect,
    output logic [31:0]       resolve_redirect_PC,
    output logic              resolve_epoch
);

    logic              w_accept;
    logic              w_miss;
    logic [31:0]       w_actual;
    logic [3:0]        w_ras_in;
    logic [3:0]        w_ras_rec;
    logic [3:0]        w_be;
    logic [7:0]        w_idx;
    logic [7:0]        w_byte_in;
    logic [7:0]        w_new_byte;
    logic [23:0]       w_meta_out;
    logic              w_unused_lu;

    logic              r_update;
    logic [31:0]       r_pc;
    logic [31:0]       r_target;
    logic              r_dir;
    logic              r_miss;
    logic [META_W-1:0] r_meta;
    logic              r_recover;
    logic              r_redirect;
    logic [31:0]       r_redirect_pc;
    logic              r_epoch;

    assign w_accept    = ex_valid & (ex_epoch == r_epoch) & ~resolve_stall;
    assign w_actual    = ex_a_dir ? ex_a_target : (ex_PC + 32'd4);
    assign w_miss      = (ex_p_dir != ex_a_dir) | (ex_p_target != w_actual);
    assign w_ras_in    = ex_meta[RAS_HI:RAS_LO];
    assign w_be        = ex_is_cond ? (4'b0001 << ex_PC[5:4]) : 4'b0000;
    assign w_idx       = ex_meta[IDX_HI:IDX_LO];
    assign w_unused_lu = ^ex_meta[LU_IDX_HI:IDX_HI+1];

    always_comb begin
        w_ras_rec = w_ras_in;
        if (ex_is_call)     w_ras_rec = w_ras_in + 4'd1;
        else if (ex_is_ret) w_ras_rec = w_ras_in - 4'd1;
    end

`ifdef SOIN_BPU_FWD_EN
    logic       r_fwd_vld;
    logic [7:0] r_fwd_idx;
    logic [3:0] r_fwd_be;
    logic [7:0] r_fwd_byte;
    logic       w_fwd_hit;

    assign w_fwd_hit = r_fwd_vld & ex_is_cond & (r_fwd_idx == w_idx) & (r_fwd_be == w_be);
    assign w_byte_in = w_fwd_hit ? r_fwd_byte : ex_meta[IN_BYTE_HI:IN_BYTE_LO];

    // A redirect means the table may have moved on; never forward across an epoch change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fwd_vld  <= 1'b0;
            r_fwd_idx  <= '0;
            r_fwd_be   <= '0;
            r_fwd_byte <= '0;
        end else if (w_accept) begin
            if (w_miss) begin
                r_fwd_vld <= 1'b0;
            end else if (ex_is_cond) begin
                r_fwd_vld  <= 1'b1;
                r_fwd_idx  <= w_idx;
                r_fwd_be   <= w_be;
                r_fwd_byte <= w_new_byte;
            end
        end
    end
`else
    assign w_byte_in = ex_meta[IN_BYTE_HI:IN_BYTE_LO];
`endif

    soin_bpredictor_ctr_update #(
        .CTR_MAX (CTR_W'(CTR_MAX))
    ) u_ctr_update (
        .i_byte (w_byte_in),
        .i_slot (ex_PC[3:2]),
        .i_dir  (ex_a_dir),
        .o_byte (w_new_byte)
    );

    assign w_meta_out = {w_ras_rec, w_be, w_new_byte, w_idx};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_update      <= 1'b0;
            r_pc          <= '0;
            r_target      <= '0;
            r_dir         <= 1'b0;
            r_miss        <= 1'b0;
            r_meta        <= '0;
            r_recover     <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_epoch       <= 1'b0;
        end else if (!resolve_stall) begin
            r_update   <= w_accept & ex_is_cond;
            r_recover  <= w_accept & w_miss;
            r_redirect <= w_accept & w_miss;
            if (w_accept) begin
                r_pc          <= ex_PC;
                r_target      <= w_actual;
                r_dir         <= ex_a_dir;
                r_miss        <= w_miss;
                r_meta        <= META_W'(w_meta_out);
                r_redirect_pc <= w_actual;
                if (w_miss) r_epoch <= ~r_epoch;
            end
        end
    end

    assign execute_bpredictor_update      = r_update;
    assign execute_bpredictor_PC          = r_pc;
    assign execute_bpredictor_target      = r_target;
    assign execute_bpredictor_dir         = r_dir;
    assign execute_bpredictor_miss        = r_miss;
    assign execute_bpredictor_meta        = r_meta;
    assign execute_bpredictor_recover_ras = r_recover;
    assign resolve_redirect               = r_redirect;
    assign resolve_redirect_PC            = r_redirect_pc;
    assign resolve_epoch                  = r_epoch;

endmodule

// File: tb/tb_soin_bpredictor_resolve.sv
// Self-checking bench for soin_bpredictor_resolve: directed literal cases plus random traffic vs a model.
module tb_soin_bpredictor_resolve;

    localparam int META_W = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b1;
    logic              resolve_stall = 1'b0;
    logic              ex_valid = 1'b0;
    logic [31:0]       ex_PC = '0;
    logic [META_W-1:0] ex_meta = '0;
    logic              ex_p_dir = 1'b0;
    logic [31:0]       ex_p_target = '0;
    logic              ex_is_cond = 1'b0;
    logic              ex_is_call = 1'b0;
    logic              ex_is_ret = 1'b0;
    logic              ex_epoch = 1'b0;
    logic              ex_a_dir = 1'b0;
    logic [31:0]       ex_a_target = '0;
    logic              execute_bpredictor_update;
    logic [31:0]       execute_bpredictor_PC;
    logic [31:0]       execute_bpredictor_target;
    logic              execute_bpredictor_dir;
    logic              execute_bpredictor_miss;
    logic [META_W-1:0] execute_bpredictor_meta;
    logic              execute_bpredictor_recover_ras;
    logic              resolve_redirect;
    logic [31:0]       resolve_redirect_PC;
    logic              resolve_epoch;

    soin_bpredictor_resolve #(.META_W(META_W), .CTR_MAX(3)) dut (
        .clk                            (clk),
        .reset                          (reset),
        .resolve_stall                  (resolve_stall),
        .ex_valid                       (ex_valid),
        .ex_PC                          (ex_PC),
        .ex_meta                        (ex_meta),
        .ex_p_dir                       (ex_p_dir),
        .ex_p_target                    (ex_p_target),
        .ex_is_cond                     (ex_is_cond),
        .ex_is_call                     (ex_is_call),
        .ex_is_ret                      (ex_is_ret),
        .ex_epoch                       (ex_epoch),
        .ex_a_dir                       (ex_a_dir),
        .ex_a_target                    (ex_a_target),
        .execute_bpredictor_update      (execute_bpredictor_update),
        .execute_bpredictor_PC          (execute_bpredictor_PC),
        .execute_bpredictor_target      (execute_bpredictor_target),
        .execute_bpredictor_dir         (execute_bpredictor_dir),
        .execute_bpredictor_miss        (execute_bpredictor_miss),
        .execute_bpredictor_meta        (execute_bpredictor_meta),
        .execute_bpredictor_recover_ras (execute_bpredictor_recover_ras),
        .resolve_redirect               (resolve_redirect),
        .resolve_redirect_PC            (resolve_redirect_PC),
        .resolve_epoch                  (resolve_epoch)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference counter training: unpack four counters, bump one, repack.
    function automatic bit [7:0] train(input bit [7:0] b, input int slot, input bit taken);
        int c[4];
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) c[i] = (int'(b) >> (2 * i)) % 4;
        if (taken) c[slot] = (c[slot] >= 3) ? 3 : c[slot] + 1;
        else       c[slot] = (c[slot] <= 0) ? 0 : c[slot] - 1;
        for (int i = 0; i < 4; i++) r += c[i] * (4 ** i);
        return r[7:0];
    endfunction

    bit        m_epoch = 1'b0;
    bit        m_update = 1'b0, m_recover = 1'b0, m_redirect = 1'b0, m_fresh = 1'b0;
    bit        m_miss = 1'b0, m_dir = 1'b0, m_cond = 1'b0;
    bit [31:0] m_pc = '0, m_target = '0;
    bit [3:0]  m_ras = '0, m_be = '0;
    bit [7:0]  m_byte = '0, m_idx = '0;
    bit        f_vld = 1'b0;
    bit [7:0]  f_idx = '0, f_byte = '0;
    bit [3:0]  f_be = '0;
    bit        acc, miss;
    bit [31:0] a_pc;
    bit [7:0]  src;

    always @(posedge clk) begin
        if (reset) begin
            m_epoch = 0; m_update = 0; m_recover = 0; m_redirect = 0; m_fresh = 0; f_vld = 0;
        end else if (!resolve_stall) begin
            acc  = ex_valid && (ex_epoch == m_epoch);
            miss = 0;
            if (acc) begin
                a_pc   = ex_a_dir ? ex_a_target : ex_PC + 32'd4;
                miss   = (ex_p_dir != ex_a_dir) || (ex_p_target != a_pc);
                m_pc   = ex_PC;
                m_target = a_pc;
                m_dir  = ex_a_dir;
                m_miss = miss;
                m_cond = ex_is_cond;
                m_ras  = 4'((int'(ex_meta[23:20]) + (ex_is_call ? 1 : (ex_is_ret ? 15 : 0))) % 16);
                m_be   = ex_is_cond ? 4'(1 << int'(ex_PC[5:4])) : 4'd0;
                m_idx  = ex_meta[7:0];
                src    = ex_meta[19:12];
`ifdef SOIN_BPU_FWD_EN
                if (f_vld && ex_is_cond && f_idx == m_idx && f_be == m_be) src = f_byte;
                if (miss) f_vld = 0;
                else if (ex_is_cond) begin
                    f_vld = 1; f_idx = m_idx; f_be = m_be; f_byte = train(src, int'(ex_PC[3:2]), ex_a_dir);
                end
`endif
                m_byte = train(src, int'(ex_PC[3:2]), ex_a_dir);
                if (miss) m_epoch = ~m_epoch;
            end
            m_fresh    = acc;
            m_update   = acc && ex_is_cond;
            m_recover  = acc && miss;
            m_redirect = acc && miss;
        end
        #1;
        chk("update", 32'(execute_bpredictor_update), 32'(m_update));
        chk("recover_ras", 32'(execute_bpredictor_recover_ras), 32'(m_recover));
        chk("redirect", 32'(resolve_redirect), 32'(m_redirect));
        chk("epoch", 32'(resolve_epoch), 32'(m_epoch));
        if (m_fresh) begin
            chk("pc", execute_bpredictor_PC, m_pc);
            chk("target", execute_bpredictor_target, m_target);
            chk("dir", 32'(execute_bpredictor_dir), 32'(m_dir));
            chk("miss", 32'(execute_bpredictor_miss), 32'(m_miss));
            chk("ras_idx", 32'(execute_bpredictor_meta[23:20]), 32'(m_ras));
            chk("be", 32'(execute_bpredictor_meta[19:16]), 32'(m_be));
            if (m_miss) chk("redirect_pc", resolve_redirect_PC, m_target);
            if (m_cond) begin
                chk("new_byte", 32'(execute_bpredictor_meta[15:8]), 32'(m_byte));
                chk("tbl_idx", 32'(execute_bpredictor_meta[7:0]), 32'(m_idx));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [23:0] meta, input logic pdir,
                           input logic [31:0] ptgt, input logic cond, input logic call,
                           input logic ret, input logic ep, input logic adir, input logic [31:0] atgt);
        ex_valid = 1'b1; ex_PC = pc; ex_meta = meta; ex_p_dir = pdir; ex_p_target = ptgt;
        ex_is_cond = cond; ex_is_call = call; ex_is_ret = ret; ex_epoch = ep;
        ex_a_dir = adir; ex_a_target = atgt;
    endtask

    logic [31:0] r_pc, r_at, r_a;
    logic        r_ad;
    int          kind;

    initial begin
        step(); step();
        chk("rst_update", 32'(execute_bpredictor_update), 32'h0);
        chk("rst_redirect", 32'(resolve_redirect), 32'h0);
        chk("rst_epoch", 32'(resolve_epoch), 32'h0);
        chk("rst_meta", 32'(execute_bpredictor_meta), 32'h0);
        chk("rst_pc", execute_bpredictor_PC, 32'h0);
        reset = 1'b0;

        resolve(32'h104, {4'd3, 8'h00, 12'h0AB}, 0, 32'h108, 1, 0, 0, 0, 0, 32'h900);
        step();
        chk("t1_update", 32'(execute_bpredictor_update), 32'h1);
        chk("t1_miss", 32'(execute_bpredictor_miss), 32'h0);
        chk("t1_byte", 32'(execute_bpredictor_meta[15:8]), 32'h00);
        chk("t1_be", 32'(execute_bpredictor_meta[19:16]), 32'h1);
        chk("t1_redirect", 32'(resolve_redirect), 32'h0);

        resolve(32'h10C, {4'd3, 8'hC0, 12'h0CD}, 1, 32'h300, 1, 0, 0, 0, 1, 32'h300);
        step();
        chk("t2_byte", 32'(execute_bpredictor_meta[15:8]), 32'hC0);
        chk("t2_miss", 32'(execute_bpredictor_miss), 32'h0);

        resolve(32'h208, {4'd5, 8'h55, 12'h011}, 1, 32'h600, 1, 0, 0, 0, 0, 32'h600);
        step();
        chk("t3_miss", 32'(execute_bpredictor_miss), 32'h1);
        chk("t3_redirect_pc", resolve_redirect_PC, 32'h20C);
        chk("t3_epoch", 32'(resolve_epoch), 32'h1);

        resolve(32'h300, {4'd5, 8'h55, 12'h011}, 1, 32'h600, 1, 0, 0, 0, 0, 32'h600);
        step();
        chk("stale_update", 32'(execute_bpredictor_update), 32'h0);
        chk("stale_redirect", 32'(resolve_redirect), 32'h0);
        chk("stale_recover", 32'(execute_bpredictor_recover_ras), 32'h0);

        resolve(32'h440, {4'd0, 8'h00, 12'h000}, 1, 32'h400, 0, 0, 1, 1, 1, 32'h500);
        step();
        chk("t4_recover", 32'(execute_bpredictor_recover_ras), 32'h1);
        chk("t4_ras", 32'(execute_bpredictor_meta[23:20]), 32'hF);
        chk("t4_redirect_pc", resolve_redirect_PC, 32'h500);
        chk("t4_update", 32'(execute_bpredictor_update), 32'h0);

        ex_valid = 1'b0;
        step();
        resolve_stall = 1'b1;
        resolve(32'h500, {4'd2, 8'h00, 12'h022}, 0, 32'h504, 1, 0, 0, 0, 1, 32'h700);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_hold_redirect", 32'(resolve_redirect), 32'h0);
            chk("t5_hold_epoch", 32'(resolve_epoch), 32'h0);
        end
        resolve_stall = 1'b0;
        step();
        chk("t5_redirect", 32'(resolve_redirect), 32'h1);
        chk("t5_redirect_pc", resolve_redirect_PC, 32'h700);
        ex_valid = 1'b0;
        step();
        chk("t5_single_pulse", 32'(resolve_redirect), 32'h0);

        resolve(32'h100, {4'd0, 8'h00, 12'h055}, 1, 32'h180, 1, 0, 0, 1, 1, 32'h180);
        step();
        chk("t6_first", 32'(execute_bpredictor_meta[15:8]), 32'h01);
        step();
`ifdef SOIN_BPU_FWD_EN
        chk("t6_second", 32'(execute_bpredictor_meta[15:8]), 32'h02);
`else
        chk("t6_second", 32'(execute_bpredictor_meta[15:8]), 32'h01);
`endif
        ex_valid = 1'b0;
        step();

        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 499) == 0);
            resolve_stall = ($urandom_range(0, 99) < 12);
            kind = int'($urandom_range(0, 9));
            r_pc = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
            r_at = 32'($urandom_range(0, 32'h3FFF)) << 2;
            r_ad = (kind <= 5) ? 1'($urandom_range(0, 1)) : 1'b1;
            r_a  = r_ad ? r_at : r_pc + 32'd4;
            resolve(r_pc,
                    {4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 12'($urandom_range(0, 7))},
                    ($urandom_range(0, 99) < 80) ? r_ad : ~r_ad,
                    ($urandom_range(0, 99) < 80) ? r_a : (32'($urandom_range(0, 32'h3FFF)) << 2),
                    kind <= 5, kind == 6, kind == 7,
                    ($urandom_range(0, 99) < 85) ? m_epoch : ~m_epoch,
                    r_ad, r_at);
            ex_valid = ($urandom_range(0, 99) < 75);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/soin_bpredictor_resolve.md
Name: soin_bpredictor_resolve

Overview:
Execute-side resolution and update unit for the bimodal/GHR branch predictor.
- Accepts each resolved control-flow instruction together with the fetch-time prediction and fetch meta.
- Compares the actual direction and target with the prediction.
- Produces the predictor update bundle (execute_bpredictor_*), the fetch redirect, and RAS recovery.
- Tracks a mispredict epoch so that wrong-path resolves are dropped.

Parameters:
META_W, 24, meta width (equal to `BP_META_WIDTH).
CTR_MAX, 3, 2-bit saturating counter ceiling.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
resolve_stall  in  1  freezes all registers and holds all outputs
ex_valid  in  1  resolved control-flow instruction present this cycle
ex_PC  in  32  instruction PC
ex_meta  in  META_W  fetch meta: [23:20] ras_index, [19:12] counter byte, [11:0] lu_index
ex_p_dir  in  1  predicted direction
ex_p_target  in  32  predicted next PC
ex_is_cond  in  1  conditional branch
ex_is_call  in  1  call
ex_is_ret  in  1  return
ex_epoch  in  1  epoch tag captured at fetch
ex_a_dir  in  1  actual direction
ex_a_target  in  32  actual taken target
execute_bpredictor_update  out  1  counter write and GHR shift strobe
execute_bpredictor_PC  out  32  registered ex_PC
execute_bpredictor_target  out  32  actual next PC
execute_bpredictor_dir  out  1  actual direction
execute_bpredictor_miss  out  1  mispredict
execute_bpredictor_meta  out  META_W  update meta: [23:20] RAS recover index, [19:16] byte enable, [15:8] new counter byte, [7:0] table index
execute_bpredictor_recover_ras  out  1  RAS restore strobe
resolve_redirect  out  1  fetch redirect
resolve_redirect_PC  out  32  redirect PC
resolve_epoch  out  1  current epoch, stamped by fetch

Behaviour:
- Latency: one cycle. Outputs are registered from the accepted ex_* inputs.
- All outputs are valid for exactly one cycle unless resolve_stall is high, in which case they hold.
- Accept: ex_valid & (ex_epoch == resolve_epoch) & ~resolve_stall. A stale-epoch input is dropped: no strobe of any kind.
- Actual next PC (A) = ex_a_dir ? ex_a_target : ex_PC+4.
- Miss = (ex_p_dir != ex_a_dir) | (ex_p_target != A).
- On accepted miss:
  - resolve_redirect=1, resolve_redirect_PC=A.
  - resolve_epoch toggles on the same edge that registers the outputs.
  - execute_bpredictor_recover_ras=1.
- RAS recover index:
  - call: ras_index+1.
  - ret: ras_index-1.
  - otherwise: ras_index.
  - Mod-16 wrap: 4'hF+1=0, 0-1=4'hF.
- Counter update (ex_is_cond only):
  - Slot = counter byte >> (2*PC[3:2]).
  - Taken: increment, saturating at CTR_MAX. Not taken: decrement, saturating at 0.
  - Other three slots of the byte are unchanged.
  - Byte enable = one-hot(PC[5:4]).
  - Table index = lu_index[7:0].
- execute_bpredictor_update = accepted & ex_is_cond.
- Unconditional, call and ret instructions: update=0, byte enable=0. They may still miss, redirect and recover the RAS.
- Simultaneous stall and valid: the input is not accepted. Upstream holds ex_* until stall drops.
- Reset (synchronous):
  - All strobes 0, resolve_epoch=0, all data outputs 0.
  - Any in-flight resolve is discarded.
  - Forward register invalid.

Optional Feature:
SOIN_BPU_FWD_EN.
- Defined: a last-write register {valid, index, be, byte} captures every update.
  - A later conditional resolve with equal index and be uses the stored byte instead of the meta byte.
  - This closes the stale-read hazard on back-to-back updates to the same byte.
  - Register is invalidated on reset and on an epoch toggle.
- Undefined: the meta byte is always used. Repeated updates may lose increments, which is functionally safe and costs accuracy only.

Decomposition:
- Shared header gets:
  - META field offsets (RAS_HI/LO, BE_HI/LO, BYTE_HI/LO, IDX_HI/LO, LU_IDX_HI/LO).
  - CTR width.
  - Counter saturate constants.
- One sub-module: soin_bpredictor_ctr_update. It is combinational: byte, slot, dir in; new byte out. It is reused by the predictor's training logic.

Test Plan:
1. Cond at PC 0x104, byte 0x00, p_dir=0, a_dir=0 -> update=1, miss=0, meta[15:8]=0x00, be=4'b0001, no redirect.
2. Cond at PC 0x10C, byte 0xC0, p_dir=1, a_dir=1, target match -> new byte 0xC0 (saturated), miss=0.
3. Cond at PC 0x208, p_dir=1, a_dir=0 -> miss=1, redirect_PC=0x20C, epoch 0->1, next resolve tagged epoch 0 is dropped (no strobes).
4. Ret with ras_index=0, ex_p_target=0x400, ex_a_target=0x500 -> miss, recover_ras=1, meta[23:20]=4'hF, redirect 0x500, update=0.
5. resolve_stall=1 with a mispredict present -> outputs hold, epoch unchanged. Release -> exactly one redirect pulse.
6. With SOIN_BPU_FWD_EN: two taken cond resolves, same index and byte, meta byte 0x00 -> bytes 0x01 then 0x02. Without the macro -> 0x01 both times.
